// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_pkg
// Brief    : Shared AHB encodings, master count and burst-length helper.
// Revision : 1.0
// ============================================================================
package ahb_pkg;

    localparam int MASTER_NUM = 3;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] c_hburst_single = 3'b000;
    localparam logic [2:0] c_hburst_incr   = 3'b001;
    localparam logic [2:0] c_hburst_wrap4  = 3'b010;
    localparam logic [2:0] c_hburst_incr4  = 3'b011;
    localparam logic [2:0] c_hburst_wrap8  = 3'b100;
    localparam logic [2:0] c_hburst_incr8  = 3'b101;
    localparam logic [2:0] c_hburst_wrap16 = 3'b110;
    localparam logic [2:0] c_hburst_incr16 = 3'b111;

    localparam logic [1:0] c_hresp_okay  = 2'b00;
    localparam logic [1:0] c_hresp_error = 2'b01;
    localparam logic [1:0] c_hresp_retry = 2'b10;
    localparam logic [1:0] c_hresp_split = 2'b11;

    // Beats still owed after the NONSEQ of a fixed-length burst; 0 = undefined length.
    function automatic logic [3:0] burst_remaining(input logic [2:0] hburst);
        case (hburst)
            c_hburst_wrap4,  c_hburst_incr4:  burst_remaining = 4'd3;
            c_hburst_wrap8,  c_hburst_incr8:  burst_remaining = 4'd7;
            c_hburst_wrap16, c_hburst_incr16: burst_remaining = 4'd15;
            default:                          burst_remaining = 4'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_burst_tracker.sv
`default_nettype none
// ============================================================================
// Module   : ahb_burst_tracker
// Brief    : IDLE/SINGLE/BURST tracker with beat counting and early-termination pulse.
// Revision : 1.0
// ============================================================================
module ahb_burst_tracker (
    input  logic       Hclk,
    input  logic       Hresetn,
    input  logic       Hready,
    input  logic [1:0] Hresp,
    input  logic [1:0] htrans,
    input  logic [2:0] hburst,
    input  logic       handover,
    output logic       burst_active,
    output logic [3:0] beat_cnt,
    output logic       early_term
);
    import ahb_pkg::*;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_single = 2'd1;
    localparam logic [1:0] c_st_burst  = 2'd2;

    logic [1:0] r_state, w_nxt_state, w_new_state;
    logic [3:0] r_rem, w_nxt_rem, w_new_rem;
    logic [3:0] r_cnt, w_nxt_cnt, w_cnt_inc;
    logic       r_early, w_early, r_burst_active;
    logic       w_error, w_live;
    htrans_e    w_trans;

    assign w_trans     = htrans_e'(htrans);
    assign w_error     = (Hresp == c_hresp_error);
    assign w_live      = (r_state == c_st_burst) && (r_rem != 4'd0);
    assign w_new_rem   = burst_remaining(hburst);
    assign w_new_state = (w_new_rem != 4'd0) ? c_st_burst : c_st_single;
    assign w_cnt_inc   = (r_cnt == 4'hF) ? 4'hF : r_cnt + 4'd1;

    always_ff @(posedge Hclk or negedge Hresetn) begin : p_state
        if (!Hresetn) begin
            r_state        <= c_st_idle;
            r_rem          <= 4'd0;
            r_cnt          <= 4'd0;
            r_early        <= 1'b0;
            r_burst_active <= 1'b0;
        end else begin
            r_state        <= w_nxt_state;
            r_rem          <= w_nxt_rem;
            r_cnt          <= w_nxt_cnt;
            r_early        <= w_early;
            r_burst_active <= (w_nxt_state == c_st_burst);
        end
    end

    // An ERROR response cuts a live burst short even while Hready is low.
    always_comb begin : p_next
        w_nxt_state = r_state;
        w_nxt_rem   = r_rem;
        w_nxt_cnt   = r_cnt;
        w_early     = 1'b0;
        if (w_error && w_live) begin
            w_early = 1'b1;
            if (Hready && (w_trans == HTRANS_NONSEQ)) begin
                w_nxt_state = w_new_state;
                w_nxt_rem   = w_new_rem;
                w_nxt_cnt   = 4'd1;
            end else begin
                w_nxt_state = c_st_idle;
                w_nxt_rem   = 4'd0;
                w_nxt_cnt   = 4'd0;
            end
        end else if (Hready) begin
            if (w_trans == HTRANS_NONSEQ) begin
                w_early     = w_live;
                w_nxt_state = w_new_state;
                w_nxt_rem   = w_new_rem;
                w_nxt_cnt   = 4'd1;
            end else begin
                w_nxt_state = c_st_idle;
                w_nxt_rem   = 4'd0;
                w_nxt_cnt   = 4'd0;
                case (r_state)
                    c_st_single: begin
                        if (w_trans == HTRANS_SEQ) begin
                            w_nxt_state = c_st_single;
                            w_nxt_cnt   = w_cnt_inc;
                        end
                    end
                    c_st_burst: begin
                        // A handover on the final SEQ beat is a normal completion.
                        if (w_live) begin
                            if (handover && !((w_trans == HTRANS_SEQ) && (r_rem == 4'd1))) begin
                                w_early = 1'b1;
                            end else if (w_trans == HTRANS_SEQ) begin
                                w_nxt_state = c_st_burst;
                                w_nxt_rem   = r_rem - 4'd1;
                                w_nxt_cnt   = w_cnt_inc;
                            end else if (w_trans == HTRANS_BUSY) begin
                                w_nxt_state = c_st_burst;
                                w_nxt_rem   = r_rem;
                                w_nxt_cnt   = r_cnt;
                            end else begin
                                w_early = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin : p_out
        burst_active = r_burst_active;
        beat_cnt     = r_cnt;
        early_term   = r_early;
    end

endmodule
`default_nettype wire

// File: rtl/ahb_bus_owner_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ahb_bus_owner_ctrl
// Brief    : Address/data-phase bus ownership tracking and master muxing.
// Revision : 1.0
// ============================================================================
module ahb_bus_owner_ctrl #(
    parameter int MASTER_NUM     = ahb_pkg::MASTER_NUM,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                        Hclk,
    input  logic                        Hresetn,
    input  logic [MASTER_NUM-1:0]       Hgrant,
    input  logic                        Hready,
    input  logic [1:0]                  Hresp,
    input  logic [MASTER_NUM-1:0][1:0]  Htrans_m,
    input  logic [MASTER_NUM-1:0][2:0]  Hburst_m,
    input  logic [MASTER_NUM-1:0][31:0] Haddr_m,
    input  logic [MASTER_NUM-1:0][31:0] Hwdata_m,
    output logic [1:0]                  Htrans,
    output logic [2:0]                  Hburst,
    output logic [31:0]                 Haddr,
    output logic [31:0]                 Hwdata,
    output logic [1:0]                  Hmaster,
    output logic [1:0]                  Hmaster_d,
    output logic                        burst_active,
    output logic [3:0]                  beat_cnt,
    output logic                        early_term,
    output logic                        grant_err
);
    import ahb_pkg::*;

    logic [1:0] r_hmaster, r_hmaster_d, w_next_master;
    logic       r_grant_err, w_multi_hot, w_handover;

    // Lowest set grant bit wins; an empty grant parks the bus on DEFAULT_MASTER.
    always_comb begin : p_grant_enc
        w_next_master = 2'(DEFAULT_MASTER);
        for (int i = MASTER_NUM - 1; i >= 0; i--) begin
            if (Hgrant[i]) begin
                w_next_master = 2'(i);
            end
        end
    end

    assign w_multi_hot = |(Hgrant & (Hgrant - MASTER_NUM'(1)));
    assign w_handover  = (w_next_master != r_hmaster);

    always_ff @(posedge Hclk or negedge Hresetn) begin : p_owner
        if (!Hresetn) begin
            r_hmaster   <= 2'(DEFAULT_MASTER);
            r_hmaster_d <= 2'(DEFAULT_MASTER);
            r_grant_err <= 1'b0;
        end else begin
            r_grant_err <= Hready & w_multi_hot;
            if (Hready) begin
                r_hmaster   <= w_next_master;
                r_hmaster_d <= r_hmaster;
            end
        end
    end

    always_comb begin : p_mux
        Htrans = 2'b00;
        Hburst = 3'b000;
        Haddr  = 32'd0;
        Hwdata = 32'd0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (r_hmaster == 2'(i)) begin
                Htrans = Htrans_m[i];
                Hburst = Hburst_m[i];
                Haddr  = Haddr_m[i];
            end
            if (r_hmaster_d == 2'(i)) begin
                Hwdata = Hwdata_m[i];
            end
        end
    end

    assign Hmaster   = r_hmaster;
    assign Hmaster_d = r_hmaster_d;
    assign grant_err = r_grant_err;

    ahb_burst_tracker u_burst_tracker (
        .Hclk         (Hclk),
        .Hresetn      (Hresetn),
        .Hready       (Hready),
        .Hresp        (Hresp),
        .htrans       (Htrans),
        .hburst       (Hburst),
        .handover     (w_handover),
        .burst_active (burst_active),
        .beat_cnt     (beat_cnt),
        .early_term   (early_term)
    );

endmodule
`default_nettype wire

// File: doc/ahb_bus_owner_ctrl.md
AHB_BUS_OWNER_CTRL -- requirements
Module: ahb_bus_owner_ctrl

Interface
REQ-001 Parameter MASTER_NUM, default 3, number of masters; taken from ahb_pkg.
REQ-002 Parameter DEFAULT_MASTER, default 0, index that owns the bus when no grant is asserted.
REQ-003 Hclk  input  1  bus clock; all state changes on its rising edge.
REQ-004 Hresetn  input  1  reset: asynchronous, active-low.
REQ-005 Hgrant  input  MASTER_NUM  one-hot grant vector from the arbiter; bit i = master i.
REQ-006 Hready  input  1  bus HREADY; qualifies every phase transfer.
REQ-007 Hresp  input  2  slave response; ERROR = 2'b01.
REQ-008 Htrans_m  input  MASTER_NUM x 2  per-master HTRANS.
REQ-009 Hburst_m  input  MASTER_NUM x 3  per-master HBURST.
REQ-010 Haddr_m  input  MASTER_NUM x 32  per-master HADDR.
REQ-011 Hwdata_m  input  MASTER_NUM x 32  per-master HWDATA.
REQ-012 Htrans, Hburst, Haddr  output  2/3/32  muxed address-phase control from the address owner.
REQ-013 Hwdata  output  32  muxed write data from the data owner.
REQ-014 Hmaster  output  2  registered address-phase owner index.
REQ-015 Hmaster_d  output  2  registered data-phase owner index.
REQ-016 burst_active  output  1  registered; high while a fixed-length burst is in progress.
REQ-017 beat_cnt  output  4  registered count of accepted beats in the current burst.
REQ-018 early_term  output  1  one-cycle pulse on an early burst termination.
REQ-019 grant_err  output  1  one-cycle pulse when Hgrant is sampled multi-hot.

Function
REQ-020 Hmaster SHALL load the encoded Hgrant index on each Hclk edge with Hready=1 and SHALL hold when Hready=0.
REQ-021 Hgrant=0 when sampled SHALL load DEFAULT_MASTER.
REQ-022 Hgrant multi-hot when sampled SHALL load the lowest set index and pulse grant_err for one cycle.
REQ-023 Hmaster_d SHALL load the previous Hmaster on each Hready=1 edge, giving exactly one accepted-transfer lag.
REQ-024 Htrans, Hburst and Haddr SHALL be combinational selects of Htrans_m, Hburst_m and Haddr_m indexed by Hmaster.
REQ-025 Hwdata SHALL be the combinational select of Hwdata_m indexed by Hmaster_d; zero added latency.
REQ-026 The burst tracker SHALL implement the FSM states IDLE, SINGLE and BURST.
REQ-027 Every transition SHALL be qualified by Hready=1, except the ERROR transition in REQ-033.
REQ-028 From any state, muxed NONSEQ with Hburst=SINGLE or INCR -> SINGLE, beat_cnt=1, burst_active=0.
REQ-029 From any state, NONSEQ with INCR4/WRAP4, INCR8/WRAP8 or INCR16/WRAP16 -> BURST, with remaining = 3/7/15, beat_cnt=1, burst_active=1.
REQ-030 In BURST, SEQ SHALL decrement remaining and increment beat_cnt; beat_cnt saturates at 15.
REQ-031 In BURST, SEQ with remaining=1 SHALL go to IDLE on the following Hready=1 edge; that is a normal completion with no early_term.
REQ-032 In BURST, BUSY SHALL hold remaining and beat_cnt.
REQ-033 In BURST with remaining>0, any of the following SHALL pulse early_term and go to IDLE, or to the new NONSEQ's state:
- IDLE or NONSEQ transfer;
- Hmaster change;
- Hresp=ERROR, which acts on the first error cycle regardless of Hready.
REQ-034 SINGLE with IDLE or BUSY SHALL go to IDLE, beat_cnt=0; SEQ in SINGLE (INCR) SHALL increment beat_cnt.
REQ-035 Simultaneous handover and final SEQ beat (remaining=1) SHALL NOT pulse early_term.
REQ-036 Simultaneous early_term and grant_err SHALL pulse both outputs.

Reset
REQ-037 Hresetn low SHALL asynchronously set Hmaster=Hmaster_d=DEFAULT_MASTER, FSM=IDLE, remaining=0, beat_cnt=0, burst_active=0, early_term=0, grant_err=0.
REQ-038 Reset mid-burst SHALL discard the burst; the first post-reset transfer is treated as new.

Structure
REQ-039 The shared package ahb_pkg SHALL hold:
- MASTER_NUM;
- the HTRANS enum (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11);
- the HBURST encodings;
- the HRESP encodings;
- the burst-length function.
REQ-040 The burst FSM and counters SHALL be a sub-module ahb_burst_tracker; ownership registers and muxes SHALL stay in the top module.

Verification
REQ-041 Hgrant=3'b010, Hready=1, one edge -> Hmaster=1; next edge -> Hmaster_d=1, Hwdata=Hwdata_m[1].
REQ-042 Master 0 INCR4 (NONSEQ + 3 SEQ, Hready=1) -> beat_cnt 1,2,3,4, burst_active falls after beat 4, early_term never asserted.
REQ-043 INCR8 with IDLE after beat 3 -> early_term pulse once, FSM IDLE, beat_cnt=0.
REQ-044 WRAP4 with Hready=0 for 2 cycles and one BUSY -> beat_cnt holds, completes at 4 beats without early_term.
REQ-045 Hgrant=3'b110 -> Hmaster=1, grant_err=1 for one cycle; Hgrant=0 -> Hmaster=DEFAULT_MASTER.
REQ-046 Hresetn low during beat 2 of INCR16 -> all outputs at reset values immediately, before the next edge.
